frame_accumulator: RTL and testbench
====================================

# frame_accumulator

Sequential consumer/driver for the team's n-bit ripple-carry adder (RippleN).
- Accepts a stream of n-bit words over a valid/ready handshake and sums each frame of K words into an n-bit register, with a sticky carry-out flag.
- Presents each completed frame total downstream over a second valid/ready handshake.
- Sits directly downstream of RippleN: one RippleN instance adds the incoming word to the running total every accepted cycle.

## Interface
Parameters:
- n, 4, data and accumulator width in bits (n >= 1)
- K, 4, words per frame (K >= 1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- clr  input  1  synchronous frame abort; same effect as rst on internal state
- in_valid  input  1  upstream word D is valid
- in_ready  output  1  block can accept a word this cycle
- D  input  n  input word
- out_valid  output  1  frame total S / C is valid
- out_ready  input  1  downstream accepts the frame total
- S  output  n  frame sum modulo 2^n (registered)
- C  output  1  sticky carry: 1 if any addition in the frame carried out of bit n-1

## Operation
- Two states:
  - ACC: collecting words.
  - HOLD: presenting the result.
- Internal count cnt spans 0..K-1.
- Datapath: RippleN(A = acc, B = D) produces sum and carry. Carry-in is 0 by RippleN construction.
- Accept = in_valid && in_ready.
- in_ready = (state == ACC) && !rst && !clr, combinational from state and the control inputs.
- ACC, on accept:
  - acc <= sum; cv <= cv | carry.
  - If cnt == K-1: state <= HOLD, cnt <= 0, S <= sum, C <= cv | carry, out_valid <= 1.
  - Otherwise: cnt <= cnt + 1.
- ACC, no accept: all state holds. Gaps in in_valid are allowed anywhere in a frame.
- HOLD:
  - in_ready = 0.
  - S, C and out_valid are stable until out_valid && out_ready.
  - On that transfer: out_valid <= 0, acc <= 0, cv <= 0, state <= ACC.
  - S and C keep their last value after the transfer; they are meaningful only while out_valid = 1.
- Arithmetic:
  - S wraps modulo 2^n.
  - C is the OR of every carry out within the frame, including the first add (acc = 0, so carry = 0).
  - No saturation.
- rst, or clr (when rst = 0), highest priority:
  - state <= ACC, cnt <= 0, acc <= 0, cv <= 0, out_valid <= 0, S <= 0, C <= 0.
  - A word presented in the same cycle is not accepted (in_ready = 0).
  - A pending HOLD result is discarded even if out_ready = 1 in that cycle.
- K = 1: every accepted word produces a frame. S = D and C = 0 in that case.

## Timing
- Reset values: S = 0, C = 0, out_valid = 0.
  - in_ready = 0 while rst is high.
  - in_ready = 1 in the first cycle after rst deasserts.
- Latency: out_valid rises on the same clock edge that accepts the K-th word, so it is visible 1 cycle after that word's handshake cycle.
- Throughput:
  - One word per cycle in ACC.
  - HOLD lasts at least 1 cycle, so the minimum frame period is K+1 cycles.
  - No word is accepted in the cycle of an output transfer.
- Output handshake: out_valid never drops without a transfer, except on rst or clr. S and C do not change while out_valid = 1.
- RippleN is purely combinational. The critical path is n full-adder carry stages plus the acc register setup.

## Test plan
- Basic frame, n=4 K=4:
  - Stimulus: D = 3, 5, 2, 4 back-to-back, out_ready = 1.
  - Response: out_valid high 1 cycle after the 4th accept; S = 14, C = 0; in_ready = 0 for exactly 1 cycle.
- Overflow:
  - Stimulus: D = 9, 9, 1, 0.
  - Response: S = 3, C = 1. A following frame of 1, 1, 1, 1 gives S = 4, C = 0, confirming the sticky flag is cleared per frame.
- Backpressure:
  - Stimulus: complete a frame with out_ready held 0 for 5 cycles while in_valid = 1 and D = 7.
  - Response: out_valid, S and C stable for all 5 cycles; in_ready = 0; no words consumed. On out_ready = 1, transfer occurs and the next frame starts with acc = 0.
- Bubbles: in_valid toggles 1, 0, 0, 1, 0, 1, 1 with D = 1 → S = 4 only after the 4th accepted word.
- Reset/clear mid-frame:
  - rst after 2 accepted words → S = 0, C = 0, out_valid = 0; the next 4 words form a fresh frame.
  - clr asserted together with in_valid → that word is not accepted.
  - clr in HOLD with out_ready = 1 → no transfer, out_valid = 0.
- K=1, n=8: D = 200, 100 → two frames with S = 200 then S = 100, C = 0 each, and out_valid pulses separated by HOLD cycles.

Source files
------------

// File: rtl/frame_accumulator.sv
// -----------------------------------------------------------------------------
// frame_accumulator
//   Sums each frame of K n-bit words received over a valid/ready handshake
//   into an n-bit running total. A sticky flag records any carry out of bit
//   n-1 during the frame. The finished total is presented downstream over a
//   second valid/ready handshake. A single ripple-carry adder (ripple_n) adds
//   the incoming word to the running total on every accepted cycle.
//
// Parameters:
//   n  data and accumulator width in bits (n >= 1)
//   K  words per frame (K >= 1)
//
// Ports:
//   clk        in   clock, all state updates on rising edge
//   rst        in   synchronous active-high reset
//   clr        in   synchronous frame abort (same effect as rst on state)
//   in_valid   in   upstream word D is valid
//   in_ready   out  block accepts a word this cycle (combinational)
//   D          in   input word [n-1:0]
//   out_valid  out  frame total S / C is valid (registered)
//   out_ready  in   downstream accepts the frame total
//   S          out  frame sum modulo 2^n (registered)
//   C          out  sticky carry of the frame (registered)
// -----------------------------------------------------------------------------

// n-bit ripple-carry adder with carry-in tied to zero.
module ripple_n #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] sum,
    output logic         carry
);
    logic [n:0] c_s;

    assign c_s[0] = 1'b0;

    for (genvar i = 0; i < n; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c_s[i];
        assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end

    assign carry = c_s[n];
endmodule

module frame_accumulator #(
    parameter int n = 4,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] D,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] S,
    output logic         C
);
    // Counter needs at least one bit even when K = 1.
    localparam int             CW       = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] cnt_r;
    logic [n-1:0]  acc_r;
    logic          cv_r;
    logic [n-1:0]  s_r;
    logic          c_r;
    logic          out_valid_r;

    logic [n-1:0]  sum_s;
    logic          carry_s;
    logic          abort_s;
    logic          accept_s;
    logic          frame_done_s;
    logic          transfer_s;

    ripple_n #(.n(n)) u_ripple (
        .a     (acc_r),
        .b     (D),
        .sum   (sum_s),
        .carry (carry_s)
    );

    // Handshake decode and next-state selection; abort overrides everything.
    always_comb begin
        abort_s      = rst | clr;
        in_ready     = (state_r == ST_ACC) && !abort_s;
        accept_s     = in_valid && in_ready;
        frame_done_s = accept_s && (cnt_r == CNT_LAST);
        // A pending result is dropped, not transferred, when aborted.
        transfer_s   = (state_r == ST_HOLD) && out_valid_r && out_ready && !abort_s;
        state_next_s = state_r;
        if (abort_s) begin
            state_next_s = ST_ACC;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (frame_done_s) state_next_s = ST_HOLD;
                    else              state_next_s = ST_ACC;
                end
                ST_HOLD: begin
                    if (transfer_s) state_next_s = ST_ACC;
                    else            state_next_s = ST_HOLD;
                end
                default: state_next_s = ST_ACC;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_ACC;
        else     state_r <= state_next_s;
    end

    // Accumulator, word counter, sticky carry and registered result.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r       <= {CW{1'b0}};
            acc_r       <= {n{1'b0}};
            cv_r        <= 1'b0;
            s_r         <= {n{1'b0}};
            c_r         <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            acc_r <= sum_s;
            cv_r  <= cv_r | carry_s;
            if (frame_done_s) begin
                cnt_r       <= {CW{1'b0}};
                s_r         <= sum_s;
                c_r         <= cv_r | carry_s;
                out_valid_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else if (transfer_s) begin
            // S and C keep their value; only the running state is cleared.
            out_valid_r <= 1'b0;
            acc_r       <= {n{1'b0}};
            cv_r        <= 1'b0;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign out_valid = out_valid_r;
    assign S         = s_r;
    assign C         = c_r;
endmodule

// File: tb/tb_frame_accumulator.sv
// -----------------------------------------------------------------------------
// tb_frame_accumulator
//   Directed and randomized bench for frame_accumulator. The n=4 K=4 instance
//   is followed by a reference model that keeps the unwrapped integer frame
//   total; the frame sum is that total modulo 16 and the sticky carry is set
//   exactly when the total reached 16. A second n=8 K=1 instance covers the
//   single-word frame case.
// -----------------------------------------------------------------------------
module tb_frame_accumulator;
    localparam int NW = 4;
    localparam int KW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [NW-1:0] d = 4'd0;
    logic          in_ready;
    logic          out_valid;
    logic [NW-1:0] s;
    logic          c;

    logic          in_valid8 = 1'b0;
    logic          out_ready8 = 1'b0;
    logic [7:0]    d8 = 8'd0;
    logic          in_ready8;
    logic          out_valid8;
    logic [7:0]    s8;
    logic          c8;

    int vectors = 0;
    int miscompares = 0;

    frame_accumulator #(.n(NW), .K(KW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .D(d), .out_valid(out_valid), .out_ready(out_ready), .S(s), .C(c)
    );

    frame_accumulator #(.n(8), .K(1)) dut_k1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid8), .in_ready(in_ready8),
        .D(d8), .out_valid(out_valid8), .out_ready(out_ready8), .S(s8), .C(c8)
    );

    // Reference model: word count and unwrapped total of the current frame.
    int tot_a = 0;
    int cnt_a = 0;
    bit hold_a = 1'b0;
    int s_a = 0;
    bit c_a = 1'b0;

    // Model update on each rising edge from the inputs the bench applied.
    always @(posedge clk) begin
        if (rst || clr) begin
            tot_a <= 0; cnt_a <= 0; hold_a <= 1'b0; s_a <= 0; c_a <= 1'b0;
        end else if (!hold_a && in_valid) begin
            if (cnt_a == KW - 1) begin
                s_a    <= (tot_a + int'(d)) % 16;
                c_a    <= ((tot_a + int'(d)) >= 16);
                hold_a <= 1'b1;
                tot_a  <= 0;
                cnt_a  <= 0;
            end else begin
                tot_a <= tot_a + int'(d);
                cnt_a <= cnt_a + 1;
            end
        end else if (hold_a && out_ready) begin
            hold_a <= 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NW-1:0] w);
        in_valid = 1'b1;
        d = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b1; d = 4'd5;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tick(); tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (s !== 4'd0 || c !== 1'b0) begin miscompares++; $display("FAIL reset_S_C got %0d/%b want 0/0", s, c); end
        vectors++; if (out_valid8 !== 1'b0 || s8 !== 8'd0) begin miscompares++; $display("FAIL reset_k1 got %b/%0d want 0/0", out_valid8, s8); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_basic;
        logic [NW-1:0] w [4];
        w[0] = 4'd3; w[1] = 4'd5; w[2] = 4'd2; w[3] = 4'd4;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; d = w[i];
            #1;
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_%0d got %b want 1", i, in_ready); end
            tick();
            if (i < 3) begin
                vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid_%0d got %b want 0", i, out_valid); end
            end
        end
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
        vectors++; if (s !== 4'd14 || c !== 1'b0) begin miscompares++; $display("FAIL basic_S_C got %0d/%b want 14/0", s, c); end
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_hold_ready got %b want 0", in_ready); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_transfer got %b want 0", out_valid); end
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_back got %b want 1", in_ready); end
    endtask

    task automatic test_overflow;
        out_ready = 1'b0;
        send(4'd9); send(4'd9); send(4'd1); send(4'd0);
        vectors++; if (out_valid !== 1'b1 || s !== 4'd3 || c !== 1'b1) begin miscompares++; $display("FAIL overflow got v=%b S=%0d C=%b want 1/3/1", out_valid, s, c); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        send(4'd1); send(4'd1); send(4'd1); send(4'd1);
        vectors++; if (out_valid !== 1'b1 || s !== 4'd4 || c !== 1'b0) begin miscompares++; $display("FAIL overflow_clear got v=%b S=%0d C=%b want 1/4/0", out_valid, s, c); end
        out_ready = 1'b1; tick();
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send(4'd7); send(4'd7); send(4'd7); send(4'd7);
        in_valid = 1'b1; d = 4'd7;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_%0d got %b want 0", i, in_ready); end
            tick();
            vectors++; if (out_valid !== 1'b1 || s !== 4'd12 || c !== 1'b1) begin miscompares++; $display("FAIL bp_hold_%0d got v=%b S=%0d C=%b want 1/12/1", i, out_valid, s, c); end
        end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_xfer_ready got %b want 0", in_ready); end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_xfer got %b want 0", out_valid); end
        send(4'd1); send(4'd2); send(4'd3); send(4'd4);
        vectors++; if (out_valid !== 1'b1 || s !== 4'd10 || c !== 1'b0) begin miscompares++; $display("FAIL bp_next_frame got v=%b S=%0d C=%b want 1/10/0", out_valid, s, c); end
        out_ready = 1'b1; tick();
    endtask

    task automatic test_bubbles;
        logic [6:0] pat;
        int accepted;
        pat = 7'b1101001;
        accepted = 0;
        out_ready = 1'b0; d = 4'd1;
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            if (pat[i]) accepted++;
            tick();
            vectors++; if (out_valid !== (accepted == 4)) begin miscompares++; $display("FAIL bubbles_valid_%0d got %b want %0d", i, out_valid, accepted == 4); end
        end
        in_valid = 1'b0;
        vectors++; if (s !== 4'd4 || c !== 1'b0) begin miscompares++; $display("FAIL bubbles_S got %0d/%b want 4/0", s, c); end
        out_ready = 1'b1; tick();
    endtask

    task automatic test_rst_mid;
        out_ready = 1'b0;
        send(4'd5); send(4'd6);
        rst = 1'b1; in_valid = 1'b1; d = 4'd9;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ready got %b want 0", in_ready); end
        tick();
        rst = 1'b0; in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0 || s !== 4'd0 || c !== 1'b0) begin miscompares++; $display("FAIL rst_mid got v=%b S=%0d C=%b want 0/0/0", out_valid, s, c); end
        send(4'd1); send(4'd2); send(4'd3); send(4'd4);
        vectors++; if (out_valid !== 1'b1 || s !== 4'd10) begin miscompares++; $display("FAIL rst_mid_fresh got v=%b S=%0d want 1/10", out_valid, s); end
        out_ready = 1'b1; tick();
    endtask

    task automatic test_clr;
        out_ready = 1'b0;
        clr = 1'b1; in_valid = 1'b1; d = 4'd8;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL clr_ready got %b want 0", in_ready); end
        tick();
        clr = 1'b0; in_valid = 1'b0;
        send(4'd1); send(4'd1); send(4'd1);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_word_taken got %b want 0", out_valid); end
        send(4'd1);
        vectors++; if (out_valid !== 1'b1 || s !== 4'd4) begin miscompares++; $display("FAIL clr_frame got v=%b S=%0d want 1/4", out_valid, s); end
        clr = 1'b1; out_ready = 1'b1;
        tick();
        clr = 1'b0; out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0 || s !== 4'd0) begin miscompares++; $display("FAIL clr_hold got v=%b S=%0d want 0/0", out_valid, s); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            d         = 4'($urandom);
            out_ready = 1'($urandom_range(0, 2) == 0);
            clr       = 1'($urandom_range(0, 40) == 0);
            #1;
            vectors++; if (in_ready !== (!hold_a && !clr)) begin miscompares++; $display("FAIL rand_ready_%0d got %b want %b", i, in_ready, !hold_a && !clr); end
            tick();
            vectors++; if (out_valid !== hold_a) begin miscompares++; $display("FAIL rand_valid_%0d got %b want %b", i, out_valid, hold_a); end
            if (hold_a) begin
                vectors++; if (s !== 4'(s_a) || c !== c_a) begin miscompares++; $display("FAIL rand_S_C_%0d got %0d/%b want %0d/%b", i, s, c, s_a, c_a); end
            end
        end
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_k1;
        out_ready8 = 1'b1; in_valid8 = 1'b1; d8 = 8'd200;
        #1;
        vectors++; if (in_ready8 !== 1'b1) begin miscompares++; $display("FAIL k1_ready got %b want 1", in_ready8); end
        tick();
        d8 = 8'd100;
        vectors++; if (out_valid8 !== 1'b1 || s8 !== 8'd200 || c8 !== 1'b0) begin miscompares++; $display("FAIL k1_first got v=%b S=%0d C=%b want 1/200/0", out_valid8, s8, c8); end
        #1;
        vectors++; if (in_ready8 !== 1'b0) begin miscompares++; $display("FAIL k1_hold_ready got %b want 0", in_ready8); end
        tick();
        vectors++; if (out_valid8 !== 1'b0) begin miscompares++; $display("FAIL k1_gap got %b want 0", out_valid8); end
        tick();
        in_valid8 = 1'b0;
        vectors++; if (out_valid8 !== 1'b1 || s8 !== 8'd100 || c8 !== 1'b0) begin miscompares++; $display("FAIL k1_second got v=%b S=%0d C=%b want 1/100/0", out_valid8, s8, c8); end
        tick();
        vectors++; if (out_valid8 !== 1'b0) begin miscompares++; $display("FAIL k1_done got %b want 0", out_valid8); end
        out_ready8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_bubbles();
        test_rst_mid();
        test_clr();
        test_random();
        test_k1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
